// File: rtl/seq_div32_if.sv
// seq_div32_if -- request/result bundle between the core register interface
// and the sequential divider.
//   master: drives start, dividend, divisor; observes busy, done, results.
//   slave : the divider side of the same bundle.
// Signals:
//   start        request pulse, sampled by the divider only while idle
//   dividend     WIDTH-bit numerator
//   divisor      WIDTH-bit denominator
//   busy         divider is computing or presenting a result
//   done         one-cycle completion strobe
//   quotient     WIDTH-bit result, held until the next accepted start
//   remainder    WIDTH-bit result, held until the next accepted start
//   div_by_zero  captured divisor was zero, held with the results
interface seq_div32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div32.sv
// seq_div32 -- radix-2 restoring divider, one quotient bit per clock.
// Each trial subtraction runs through a chain of 4-bit carry-lookahead
// groups (T + ~divisor + 1); the carry out of the top group, together with
// the partial-remainder bit shifted out of the WIDTH-bit window, says the
// subtraction did not borrow.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; discards any division in flight
//   bus      seq_div32_if slave modport (start/operands in, busy/done/results out)
// Optional feature macro: DIV_SIGNED_EN -- two's complement operands
//   (magnitudes divided unsigned, signs fixed up on completion). When it is
//   undefined the divider is purely unsigned and no sign logic exists.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  seq_div32_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int NGRP  = WIDTH / 4;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  // 4-bit carry-lookahead adder group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Two's complement negation.
  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
    return (~x) + ONE;
  endfunction

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd;      // dividend bits still to be shifted in, MSB first
  logic [WIDTH-1:0]   r_dsr;      // divisor (magnitude)
  logic [WIDTH-1:0]   r_rem;      // partial remainder
  logic [WIDTH-1:0]   r_quo;      // quotient bits collected so far
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_t;        // trial value, one bit wider than the operands
  logic [WIDTH-1:0]   w_nd;
  logic [WIDTH-1:0]   w_diff;
  logic [NGRP:0]      w_gc;
  logic               w_nb;       // trial subtraction did not borrow
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_zero_div;

`ifdef DIV_SIGNED_EN
  logic r_qneg;
  logic r_rneg;
  assign w_a_mag   = bus.dividend[WIDTH-1] ? neg2(bus.dividend) : bus.dividend;
  assign w_b_mag   = bus.divisor[WIDTH-1]  ? neg2(bus.divisor)  : bus.divisor;
  assign w_quo_fix = r_qneg ? neg2(w_quo_nx) : w_quo_nx;
  assign w_rem_fix = r_rneg ? neg2(w_rem_nx) : w_rem_nx;
`else
  assign w_a_mag   = bus.dividend;
  assign w_b_mag   = bus.divisor;
  assign w_quo_fix = w_quo_nx;
  assign w_rem_fix = w_rem_nx;
`endif

  assign w_zero_div = (bus.divisor == {WIDTH{1'b0}});

  // Trial subtract T - divisor as T + ~divisor + 1 through the lookahead groups.
  assign w_t     = {r_rem, r_dvd[WIDTH-1]};
  assign w_nd    = ~r_dsr;
  assign w_gc[0] = 1'b1;

  for (genvar g = 0; g < NGRP; g++) begin : g_cla
    logic [4:0] w_res;
    assign w_res           = cla4(w_t[4*g +: 4], w_nd[4*g +: 4], w_gc[g]);
    assign w_diff[4*g +: 4] = w_res[3:0];
    assign w_gc[g+1]       = w_res[4];
  end

  // A set bit shifted out of the window means T exceeds any divisor.
  assign w_nb     = w_t[WIDTH] | w_gc[NGRP];
  assign w_rem_nx = w_nb ? w_diff : w_t[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_nb};

  // Next-state decode.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx = w_zero_div ? S_DONE : S_CALC;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_CALC;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register plus registered busy/done strobes derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
    end
  end

  // Operand capture, per-cycle shift/subtract, and result publication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_dvd       <= {WIDTH{1'b0}};
      r_dsr       <= {WIDTH{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_zero_div) begin
            // Results are defined directly; the raw dividend is returned.
            r_quotient  <= {WIDTH{1'b1}};
            r_remainder <= bus.dividend;
            r_dbz       <= 1'b1;
          end else if (bus.start) begin
            r_dvd <= w_a_mag;
            r_dsr <= w_b_mag;
            r_rem <= {WIDTH{1'b0}};
            r_quo <= {WIDTH{1'b0}};
            r_cnt <= CNT_W'(WIDTH - 1);
            r_dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_qneg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_rneg <= bus.dividend[WIDTH-1];
`endif
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
          end else begin
            r_quotient  <= r_quotient;
          end
        end
        S_DONE:  r_cnt <= r_cnt;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div32.sv
// tb_seq_div32 -- directed bench for seq_div32 (WIDTH=32). Expected results
// come from a behavioural divide model and are queued when a request is
// driven, then popped and compared when done is seen.
module tb_seq_div32;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  exp_t sb[$];

  seq_div32_if #(.WIDTH(W)) bus ();

  seq_div32 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dbz = 1'b0;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples #1 after each rising edge until done, up to a bound.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;                 // edge A has been taken
    bus.start    = 1'b0;
    bus.dividend = $urandom;            // operands may change after acceptance
    bus.divisor  = $urandom;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    chk({tag, "_latency"}, n, (b == 32'd0) ? 32'd0 : 32'd32);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, bus.quotient, e.q);
      chk({tag, "_r"}, bus.remainder, e.r);
      chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
    end else begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int   pulses;
    exp_t e;
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("s_m100_7", 32'hFFFF_FF9C, 32'd7);
    run_div("s_100_m7", 32'd100, 32'hFFFF_FFF9);
    run_div("s_dbz", 32'hFFFF_FF00, 32'd0);
`endif
    run_div("u_100_7", 32'd100, 32'd7);
    run_div("max_1", 32'hFFFF_FFFF, 32'd1);
    run_div("5_9", 32'd5, 32'd9);
    run_div("dbz", 32'h0000_1234, 32'd0);
    run_div("after_dbz", 32'd77, 32'd11);      // accepted two edges after the zero-divisor request
    run_div("big_dsr", 32'hFFFF_FFFF, 32'h8000_0001);
    for (int i = 0; i < 3; i++) begin
      run_div("rand", $urandom, $urandom_range(1, 65535));
    end

    // Second start while busy must be ignored.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    sb.push_back(model(32'd50, 32'd5));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("busy_q", bus.quotient, e.q);
          chk("busy_r", bus.remainder, e.r);
        end else begin
          chk("busy_extra_done", 32'd0, 32'd1);
        end
      end
    end
    chk("busy_pulses", pulses, 32'd1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_q", bus.quotient, 32'd0);
    chk("mid_rst_r", bus.remainder, 32'd0);
    chk("mid_rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    chk("mid_rst_no_done", pulses, 32'd0);
    run_div("post_rst_81_9", 32'd81, 32'd9);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
